// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Round-robin pick is kept here so it can be reused by other schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Grant index width; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {found, idx}: first set bit scanning from last+1 with wrap.
  // The previous owner is visited last, so it has lowest priority.
  function automatic logic [MAX_IDX_W:0] rr_next(
    input logic [MAX_IDX_W-1:0] last,
    input logic [MAX_REQ-1:0]   valid_vec,
    input int                   n
  );
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
    int                   j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        j = (int'(last) + k) % n;
        if (!found && valid_vec[j[MAX_IDX_W-1:0]]) begin
          found = 1'b1;
          idx   = j[MAX_IDX_W-1:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Combinational round-robin selector.
// Pads the request vector to the package maximum and reuses rr_next.
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_vec,
  input  logic [IW-1:0]      last_grant,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [MAX_REQ-1:0]   vec_pad;
  logic [MAX_IDX_W-1:0] last_pad;
  logic [MAX_IDX_W:0]   pick;

  // Widen inputs to the helper's fixed width and narrow the result back.
  always_comb begin
    vec_pad                = '0;
    vec_pad[NUM_REQ-1:0]   = valid_vec;
    last_pad               = MAX_IDX_W'(last_grant);
    pick                   = rr_next(last_pad, vec_pad, NUM_REQ);
    found                  = pick[MAX_IDX_W];
    idx                    = IW'(pick[MAX_IDX_W-1:0]);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler sharing one async-FIFO write port.
// Round-robin grants, bounded bursts, never writes into a full FIFO.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = `DATA_WIDTH,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = idx_w(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  arb_state_e      state;
  arb_state_e      state_n;
  logic [CW-1:0]   burst_cnt;
  logic [CW-1:0]   cnt_n;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   last_n;
  logic [IW-1:0]   gid_n;
  logic            busy_n;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic            last_beat;
  logic            done;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .valid_vec  (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Route the granted requester's valid and data.
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Write-port outputs; all held low in reset and while full.
  always_comb begin
    winc      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    if (!wrst && state == GRANT && !wfull) begin
      req_ready = NUM_REQ'(1) << grant_id;
      winc      = sel_valid;
      if (sel_valid) begin
        wdata = sel_data;
      end
    end
  end

  // Release on the final beat of a burst or when the owner goes quiet.
  // A full FIFO blocks both, so the grant is held across backpressure.
  always_comb begin
    last_beat = winc && (burst_cnt == CW'(MAX_BURST - 1));
    done      = !wfull && !sel_valid;
  end

  // Next-state logic for the grant FSM, counter and owner tracking.
  always_comb begin
    state_n = state;
    cnt_n   = burst_cnt;
    last_n  = last_grant;
    gid_n   = grant_id;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gid_n   = pick_idx;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        if (winc) begin
          cnt_n = burst_cnt + CW'(1);
        end
        if (last_beat || done) begin
          state_n = IDLE;
          last_n  = grant_id;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      burst_cnt  <= cnt_n;
      last_grant <= last_n;
      grant_id   <= gid_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random backpressure.
// A transaction-level model predicts ownership, beats and write data.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic              wfull;
  logic [IW-1:0]     grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int tests;
  int fails;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Requester sources: each holds a queue of pending words.
  logic [DW-1:0] q[NR][$];
  bit            en[NR];
  bit            rst_in;
  bit            full_in;

  // Reference model: owner (-1 = none), beats in burst, last owner.
  int m_owner;
  int m_cnt;
  int m_last;

  // Logs gathered from DUT outputs.
  int glog[$];
  int blog[$];
  int gaps[$];
  int wlist[$];
  int idle_run;
  bit prev_busy;
  int dut_wr;
  int dut_acc;

  function automatic int at(input int qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NR - 1;
  endtask

  task automatic model_release();
    m_last  = m_owner;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  task automatic cycle();
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    e_ready;
    bit               e_winc;
    int               e_wdata;
    int               j;
    @(negedge wclk);
    v = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && q[i].size() > 0) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = q[i][0];
      end
    end
    req_valid = v;
    req_data  = d;
    wrst      = rst_in;
    wfull     = full_in;
    #1;
    e_ready = '0;
    e_winc  = 1'b0;
    e_wdata = 0;
    if (!rst_in && m_owner >= 0) begin
      if (!full_in) e_ready[m_owner] = 1'b1;
      e_winc = v[m_owner] && !full_in;
      if (e_winc) e_wdata = int'(d[m_owner*DW +: DW]);
    end
    check("winc", int'(winc), int'(e_winc));
    check("req_ready", int'(req_ready), int'(e_ready));
    check("wdata", int'(wdata), e_wdata);
    check("busy", int'(busy), int'(m_owner >= 0));
    if (m_owner >= 0) check("grant_id", int'(grant_id), m_owner);
    check("burst_cnt", int'(dut.burst_cnt), m_cnt);
    check("winc_and_wfull", int'(winc && wfull), 0);
    check("ready_onehot", int'($countones(req_ready) <= 1), 1);

    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_id));
      blog.push_back(0);
      if (glog.size() > 1) gaps.push_back(idle_run);
    end
    if (!busy) idle_run++;
    else idle_run = 0;
    if (winc) begin
      dut_wr++;
      wlist.push_back(int'(wdata));
      if (blog.size() > 0) blog[blog.size()-1] += 1;
    end
    dut_acc += $countones(req_ready & req_valid);
    prev_busy = busy;

    for (int i = 0; i < NR; i++) begin
      if (e_ready[i] && v[i]) void'(q[i].pop_front());
    end

    if (rst_in) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        j = (m_last + k) % NR;
        if (m_owner < 0 && v[j]) m_owner = j;
      end
      m_cnt = 0;
    end else if (e_winc) begin
      m_cnt++;
      if (m_cnt == MB) model_release();
    end else if (!full_in && !v[m_owner]) begin
      model_release();
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    blog.delete();
    gaps.delete();
    wlist.delete();
    idle_run = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) begin
      q[i].delete();
      en[i] = 1'b1;
    end
    full_in = 1'b0;
    rst_in  = 1'b1;
    cycle();
    rst_in  = 1'b0;
    clear_logs();
  endtask

  initial begin
    int exp_words[$];
    int n;
    logic [DW-1:0] w;
    tests     = 0;
    fails     = 0;
    wrst      = 1'b1;
    wfull     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rst_in    = 1'b1;
    full_in   = 1'b0;
    for (int i = 0; i < NR; i++) en[i] = 1'b1;
    model_reset();
    idle_run  = 0;
    prev_busy = 1'b0;
    dut_wr    = 0;
    dut_acc   = 0;
    repeat (2) @(posedge wclk);

    // Reset state
    cycle();
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_busy", int'(busy), 0);
    rst_in = 1'b0;

    // Requester 1 alone, 6 words
    do_reset();
    for (int k = 0; k < 6; k++) begin
      w = DW'($urandom_range(0, 255));
      q[1].push_back(w);
      exp_words.push_back(int'(w));
    end
    repeat (16) cycle();
    check("s1_ngrants", glog.size(), 2);
    check("s1_g0", at(glog, 0), 1);
    check("s1_g1", at(glog, 1), 1);
    check("s1_b0", at(blog, 0), 4);
    check("s1_b1", at(blog, 1), 2);
    check("s1_gap", at(gaps, 0), 1);
    check("s1_nwords", wlist.size(), 6);
    for (int k = 0; k < 6; k++) check("s1_word", at(wlist, k), exp_words[k]);

    // All four requesters continuously valid
    do_reset();
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < 20; k++) q[i].push_back(DW'($urandom_range(0, 255)));
    end
    repeat (30) cycle();
    for (int k = 0; k < 5; k++) check("s2_order", at(glog, k), k % NR);
    for (int k = 0; k < 4; k++) check("s2_burst", at(blog, k), MB);
    for (int k = 0; k < 4; k++) check("s2_gap", at(gaps, k), 1);

    // wfull for 3 cycles after 2nd write of requester 2
    do_reset();
    for (int k = 0; k < 4; k++) q[2].push_back(DW'($urandom_range(0, 255)));
    n = 0;
    while (wlist.size() < 2 && n < 10) begin
      cycle();
      n++;
    end
    check("s3_reach", wlist.size(), 2);
    full_in = 1'b1;
    repeat (3) begin
      cycle();
      check("s3_winc", int'(winc), 0);
      check("s3_ready", int'(req_ready), 0);
      check("s3_cnt", int'(dut.burst_cnt), 2);
      check("s3_busy", int'(busy), 1);
      check("s3_gid", int'(grant_id), 2);
    end
    full_in = 1'b0;
    repeat (6) cycle();
    check("s3_total", wlist.size(), 4);
    check("s3_burst", at(blog, 0), 4);
    check("s3_ngrants", glog.size(), 1);

    // Requester 0 drops after one write, requester 3 waiting
    do_reset();
    q[0].push_back(DW'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) q[3].push_back(DW'($urandom_range(0, 255)));
    repeat (14) cycle();
    check("s4_g0", at(glog, 0), 0);
    check("s4_g1", at(glog, 1), 3);
    check("s4_b0", at(blog, 0), 1);
    check("s4_gap", at(gaps, 0), 1);

    // Reset pulse during the 3rd write of a burst
    do_reset();
    for (int k = 0; k < 6; k++) begin
      q[1].push_back(DW'($urandom_range(0, 255)));
      q[2].push_back(DW'($urandom_range(0, 255)));
    end
    n = 0;
    while (wlist.size() < 2 && n < 10) begin
      cycle();
      n++;
    end
    check("s5_reach", wlist.size(), 2);
    rst_in = 1'b1;
    cycle();
    check("s5_rst_winc", int'(winc), 0);
    rst_in = 1'b0;
    clear_logs();
    q[0].push_back(DW'($urandom_range(0, 255)));
    cycle();
    check("s5_busy", int'(busy), 0);
    repeat (6) cycle();
    check("s5_pick", at(glog, 0), 0);

    // Random backpressure with four active requesters
    do_reset();
    dut_wr  = 0;
    dut_acc = 0;
    repeat (1000) begin
      for (int i = 0; i < NR; i++) begin
        en[i] = ($urandom_range(0, 3) != 0);
        if (q[i].size() < 3) q[i].push_back(DW'($urandom_range(0, 255)));
      end
      full_in = ($urandom_range(0, 2) == 0);
      cycle();
    end
    full_in = 1'b0;
    check("s6_wr_vs_acc", dut_wr, dut_acc);
    check("s6_activity", int'(dut_wr > 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
